// File: rtl/npc_ifu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : npc_ifu_pkg
//  Description : Shared types and constants for the instruction fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package npc_ifu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_DROP = 3'd4
    } ifu_state_e;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage
`default_nettype wire

// File: rtl/ifu_pc_reg.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_pc_reg
//  Description : Fetch PC register; next PC is redirect > pc+4 > hold.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifu_pc_reg
    import npc_ifu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_redirect_valid,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_next,
    output logic              o_misaligned_next
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;

    always_comb begin
        w_pc_next = r_pc;
        if (i_redirect_valid) begin
            w_pc_next = i_redirect_pc;
        end else if (i_advance) begin
            w_pc_next = r_pc + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc              = r_pc;
    assign o_pc_next         = w_pc_next;
    assign o_misaligned_next = |w_pc_next[1:0];

endmodule
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_fetch
//  Description : Instruction fetch stage: one outstanding imem request, a
//                registered instruction slot and PC redirect handling.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch
    import npc_ifu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [DATA_W-1:0] imem_resp_data,
    input  logic              imem_resp_err,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_err
);

    ifu_state_e        r_state;
    logic              r_req_valid;
    logic [ADDR_W-1:0] r_req_addr;
    logic              r_inst_valid;
    logic [DATA_W-1:0] r_inst;
    logic [ADDR_W-1:0] r_inst_pc;
    logic              r_inst_err;

    logic [ADDR_W-1:0] w_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic              w_mis_next;
    logic              w_handshake;
    logic              w_advance;

    assign w_handshake = r_req_valid & imem_req_ready;
    assign w_advance   = (r_state == ST_HOLD) & r_inst_valid & inst_ready;

    ifu_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk               (clk),
        .rst               (rst),
        .i_redirect_valid  (redirect_valid),
        .i_redirect_pc     (redirect_pc),
        .i_advance         (w_advance),
        .o_pc              (w_pc),
        .o_pc_next         (w_pc_next),
        .o_misaligned_next (w_mis_next)
    );

    // Every path into REQ loads the request from the next PC; a misaligned
    // PC leaves req_valid low so REQ turns it into a faulted instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_req_valid  <= 1'b0;
            r_req_addr   <= RESET_PC;
            r_inst_valid <= 1'b0;
            r_inst       <= DATA_W'(NOP_INST);
            r_inst_pc    <= RESET_PC;
            r_inst_err   <= 1'b0;
        end else begin
            r_req_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_state     <= ST_REQ;
                    r_req_valid <= !w_mis_next;
                    r_req_addr  <= w_pc_next;
                end
                ST_REQ: begin
                    if (w_handshake) begin
                        r_state <= redirect_valid ? ST_DROP : ST_WAIT;
                    end else if (redirect_valid || r_req_valid) begin
                        r_req_valid <= !w_mis_next;
                        r_req_addr  <= w_pc_next;
                    end else begin
                        r_state      <= ST_HOLD;
                        r_inst_valid <= 1'b1;
                        r_inst       <= DATA_W'(NOP_INST);
                        r_inst_pc    <= w_pc;
                        r_inst_err   <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (imem_resp_valid && redirect_valid) begin
                        r_state     <= ST_REQ;
                        r_req_valid <= !w_mis_next;
                        r_req_addr  <= w_pc_next;
                    end else if (imem_resp_valid) begin
                        r_state      <= ST_HOLD;
                        r_inst_valid <= 1'b1;
                        r_inst       <= imem_resp_err ? DATA_W'(NOP_INST) : imem_resp_data;
                        r_inst_pc    <= w_pc;
                        r_inst_err   <= imem_resp_err;
                    end else if (redirect_valid) begin
                        r_state <= ST_DROP;
                    end
                end
                ST_HOLD: begin
                    if (redirect_valid || inst_ready) begin
                        r_state      <= ST_REQ;
                        r_inst_valid <= 1'b0;
                        r_req_valid  <= !w_mis_next;
                        r_req_addr   <= w_pc_next;
                    end
                end
                ST_DROP: begin
                    if (imem_resp_valid) begin
                        r_state     <= ST_REQ;
                        r_req_valid <= !w_mis_next;
                        r_req_addr  <= w_pc_next;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_req_addr;
    assign inst_valid     = r_inst_valid;
    assign inst           = r_inst;
    assign inst_pc        = r_inst_pc;
    assign inst_err       = r_inst_err;

    a_no_spurious_resp: assert property (@(posedge clk) disable iff (!rst)
        imem_resp_valid |-> (r_state == ST_WAIT || r_state == ST_DROP));

endmodule
`default_nettype wire
